// File: rtl/scarv_cop_mem_arb.sv
// Two-requester arbiter sharing one memory port between the CPU and the coprocessor.
// Round-robin on ties; the owner may keep the bus for up to LOCK_MAX back-to-back beats.
module scarv_cop_mem_arb #(
    parameter int LOCK_MAX = 4
) (
    input  logic        i_g_clk,
    input  logic        i_g_reset,

    input  logic        i_cpu_mem_cen,
    input  logic        i_cpu_mem_wen,
    input  logic [31:0] i_cpu_mem_addr,
    input  logic [31:0] i_cpu_mem_wdata,
    input  logic [3:0]  i_cpu_mem_ben,
    output logic [31:0] o_cpu_mem_rdata,
    output logic        o_cpu_mem_stall,
    output logic        o_cpu_mem_error,

    input  logic        i_cop_mem_cen,
    input  logic        i_cop_mem_wen,
    input  logic [31:0] i_cop_mem_addr,
    input  logic [31:0] i_cop_mem_wdata,
    input  logic [3:0]  i_cop_mem_ben,
    output logic [31:0] o_cop_mem_rdata,
    output logic        o_cop_mem_stall,
    output logic        o_cop_mem_error,

    output logic        o_mem_cen,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_ben,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_stall,
    input  logic        i_mem_error,

    output logic        o_arb_owner,
    output logic        o_arb_busy
);

    localparam int CW = $clog2(LOCK_MAX) + 1;
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CPU_OWN = 2'd1;
    localparam logic [1:0] ST_COP_OWN = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_lock_cnt;
    logic          r_rr_last;
    logic          r_req_wen;
    logic [31:0]   r_req_addr;
    logic [31:0]   r_req_wdata;
    logic [3:0]    r_req_ben;

    logic          w_busy;
    logic          w_owner_cop;
    logic          w_own_cen;
    logic          w_other_cen;
    logic          w_idle_grant;
    logic          w_idle_cop_wins;
    logic          w_sel_cop;
    logic          w_complete;
    logic          w_forward;
    logic          w_issue;
    logic          w_resp_error;
    logic          w_sel_wen;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [3:0]    w_sel_ben;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        w_busy          = (r_state != ST_IDLE);
        w_owner_cop     = (r_state == ST_COP_OWN);
        w_own_cen       = w_owner_cop ? i_cop_mem_cen : i_cpu_mem_cen;
        w_other_cen     = w_owner_cop ? i_cpu_mem_cen : i_cop_mem_cen;
        w_idle_grant    = i_cpu_mem_cen | i_cop_mem_cen;
        w_idle_cop_wins = i_cop_mem_cen & (~i_cpu_mem_cen | ~r_rr_last);
        w_sel_cop       = w_busy ? w_owner_cop : w_idle_cop_wins;
        w_complete      = w_busy & ~i_mem_stall;
        w_resp_error    = i_mem_error & ~i_mem_stall;
        w_forward       = w_complete & ~i_mem_error & w_own_cen &
                          (~w_other_cen | (r_lock_cnt < LOCK_MAX_C));
        w_issue         = (~w_busy & w_idle_grant) | w_forward;

        w_sel_wen       = w_sel_cop ? i_cop_mem_wen   : i_cpu_mem_wen;
        w_sel_addr      = w_sel_cop ? i_cop_mem_addr  : i_cpu_mem_addr;
        w_sel_wdata     = w_sel_cop ? i_cop_mem_wdata : i_cpu_mem_wdata;
        w_sel_ben       = w_sel_cop ? i_cop_mem_ben   : i_cpu_mem_ben;
    end

    // Between beats the last forwarded request is held; an idle bus drives zeros.
    always_comb begin
        o_mem_cen   = w_issue;
        o_mem_wen   = 1'b0;
        o_mem_addr  = 32'd0;
        o_mem_wdata = 32'd0;
        o_mem_ben   = 4'd0;
        if (w_issue) begin
            o_mem_wen   = w_sel_wen;
            o_mem_addr  = w_sel_addr;
            o_mem_wdata = w_sel_wdata;
            o_mem_ben   = w_sel_ben;
        end else if (w_busy) begin
            o_mem_wen   = r_req_wen;
            o_mem_addr  = r_req_addr;
            o_mem_wdata = r_req_wdata;
            o_mem_ben   = r_req_ben;
        end

        o_arb_owner = w_sel_cop;
        o_arb_busy  = w_busy;
    end

    always_comb begin
        o_cpu_mem_rdata = 32'd0;
        o_cpu_mem_error = 1'b0;
        o_cpu_mem_stall = i_cpu_mem_cen;
        o_cop_mem_rdata = 32'd0;
        o_cop_mem_error = 1'b0;
        o_cop_mem_stall = i_cop_mem_cen;
        if (r_state == ST_CPU_OWN) begin
            o_cpu_mem_rdata = i_mem_rdata;
            o_cpu_mem_error = w_resp_error;
            o_cpu_mem_stall = i_mem_stall;
            o_cop_mem_stall = 1'b1;
        end else if (r_state == ST_COP_OWN) begin
            o_cop_mem_rdata = i_mem_rdata;
            o_cop_mem_error = w_resp_error;
            o_cop_mem_stall = i_mem_stall;
            o_cpu_mem_stall = 1'b1;
        end
    end

    always_ff @(posedge i_g_clk) begin
        if (i_g_reset) begin
            r_state     <= ST_IDLE;
            r_lock_cnt  <= '0;
            r_rr_last   <= 1'b0;
            r_req_wen   <= 1'b0;
            r_req_addr  <= 32'd0;
            r_req_wdata <= 32'd0;
            r_req_ben   <= 4'd0;
        end else begin
            if (w_issue) begin
                r_req_wen   <= w_sel_wen;
                r_req_addr  <= w_sel_addr;
                r_req_wdata <= w_sel_wdata;
                r_req_ben   <= w_sel_ben;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_idle_grant) begin
                        r_state    <= w_idle_cop_wins ? ST_COP_OWN : ST_CPU_OWN;
                        r_rr_last  <= w_idle_cop_wins;
                        r_lock_cnt <= CW'(1);
                    end
                end
                ST_CPU_OWN, ST_COP_OWN: begin
                    if (w_forward) begin
                        if (r_lock_cnt < LOCK_MAX_C) begin
                            r_lock_cnt <= r_lock_cnt + CW'(1);
                        end
                    end else if (w_complete) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scarv_cop_mem_arb.sv
// Directed self-checking bench for scarv_cop_mem_arb: reset, single reads, tie-break,
// lock-out fairness, error responses, reset mid-transaction and lock saturation.
module tb_scarv_cop_mem_arb;

   logic        clock;
   logic        reset;
   logic        cpuCen, cpuWen, copCen, copWen;
   logic [31:0] cpuAddr, cpuWdata, copAddr, copWdata;
   logic [3:0]  cpuBen, copBen;
   logic [31:0] cpuRdata, copRdata;
   logic        cpuStall, cpuError, copStall, copError;
   logic        memCen, memWen;
   logic [31:0] memAddr, memWdata, memRdata;
   logic [3:0]  memBen;
   logic        memStall, memError;
   logic        arbOwner, arbBusy;

   int nAsserts = 0;
   int nFails   = 0;

   bit          copCenT  [14];
   logic [31:0] copAddrT [14];
   bit          cpuCenT  [14];
   logic [31:0] cpuAddrT [14];
   bit          expCenT  [14];
   bit          expOwnT  [14];
   logic [31:0] expAddrT [14];
   bit          expCopStT[14];
   bit          expCpuStT[14];

   scarv_cop_mem_arb #(.LOCK_MAX(4)) dut (
      .i_g_clk         (clock),
      .i_g_reset       (reset),
      .i_cpu_mem_cen   (cpuCen),
      .i_cpu_mem_wen   (cpuWen),
      .i_cpu_mem_addr  (cpuAddr),
      .i_cpu_mem_wdata (cpuWdata),
      .i_cpu_mem_ben   (cpuBen),
      .o_cpu_mem_rdata (cpuRdata),
      .o_cpu_mem_stall (cpuStall),
      .o_cpu_mem_error (cpuError),
      .i_cop_mem_cen   (copCen),
      .i_cop_mem_wen   (copWen),
      .i_cop_mem_addr  (copAddr),
      .i_cop_mem_wdata (copWdata),
      .i_cop_mem_ben   (copBen),
      .o_cop_mem_rdata (copRdata),
      .o_cop_mem_stall (copStall),
      .o_cop_mem_error (copError),
      .o_mem_cen       (memCen),
      .o_mem_wen       (memWen),
      .o_mem_addr      (memAddr),
      .o_mem_wdata     (memWdata),
      .o_mem_ben       (memBen),
      .i_mem_rdata     (memRdata),
      .i_mem_stall     (memStall),
      .i_mem_error     (memError),
      .o_arb_owner     (arbOwner),
      .o_arb_busy      (arbBusy)
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nAsserts++;
      if (observed !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      checkOutput(tag, 32'(observed), 32'(expected));
   endtask

   // Drop every requester and memory input to its quiet value.
   task automatic applyStimulus();
      cpuCen = 0; cpuWen = 0; cpuAddr = 0; cpuWdata = 0; cpuBen = 0;
      copCen = 0; copWen = 0; copAddr = 0; copWdata = 0; copBen = 0;
      memRdata = 0; memStall = 0; memError = 0;
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic sampleEdge();
      @(negedge clock);
   endtask

   // Two reset edges, then release; outputs must show the quiet idle state.
   task automatic doReset();
      reset = 1'b1;
      applyStimulus();
      nextCycle();
      nextCycle();
      reset = 1'b0;
   endtask

   task automatic checkQuiet(input string tag);
      sampleEdge();
      checkBit({tag, "_memcen"}, memCen, 1'b0);
      checkBit({tag, "_busy"}, arbBusy, 1'b0);
      checkBit({tag, "_owner"}, arbOwner, 1'b0);
      checkBit({tag, "_cpustall"}, cpuStall, 1'b0);
      checkBit({tag, "_copstall"}, copStall, 1'b0);
      checkBit({tag, "_cpuerr"}, cpuError, 1'b0);
      checkBit({tag, "_coperr"}, copError, 1'b0);
      checkOutput({tag, "_addr"}, memAddr, 32'd0);
   endtask

   initial begin
      copCenT   = '{1,1,1,1,1,1,1,1,1,1,1,0,0,0};
      copAddrT  = '{32'h1000,32'h1004,32'h1008,32'h100C,32'h1010,32'h1010,32'h1010,
                    32'h1010,32'h1014,32'h1018,32'h101C,32'h101C,32'h101C,32'h101C};
      cpuCenT   = '{1,1,1,1,1,1,0,1,1,1,1,1,1,0};
      cpuAddrT  = '{32'h2000,32'h2000,32'h2000,32'h2000,32'h2000,32'h2000,32'h2000,
                    32'h2004,32'h2004,32'h2004,32'h2004,32'h2004,32'h2004,32'h2004};
      expCenT   = '{1,1,1,1,0,1,0,1,1,1,1,0,1,0};
      expOwnT   = '{1,1,1,1,1,0,0,1,1,1,1,1,0,0};
      expAddrT  = '{32'h1000,32'h1004,32'h1008,32'h100C,32'h100C,32'h2000,32'h2000,
                    32'h1010,32'h1014,32'h1018,32'h101C,32'h101C,32'h2004,32'h2004};
      expCopStT = '{1,0,0,0,0,1,1,1,0,0,0,0,0,1};
      expCpuStT = '{1,1,1,1,1,1,0,1,1,1,1,1,1,0};

      doReset();
      checkQuiet("reset");

      // CPU-only read of 0x100 with two stall cycles.
      nextCycle();
      cpuCen = 1; cpuAddr = 32'h100; cpuBen = 4'hF;
      sampleEdge();
      checkBit("rd_issue_cen", memCen, 1'b1);
      checkOutput("rd_issue_addr", memAddr, 32'h100);
      checkBit("rd_issue_owner", arbOwner, 1'b0);
      checkBit("rd_issue_stall", cpuStall, 1'b1);
      for (int s = 0; s < 2; s++) begin
         nextCycle();
         memStall = 1;
         sampleEdge();
         checkBit("rd_wait_stall", cpuStall, 1'b1);
         checkBit("rd_wait_cen", memCen, 1'b0);
         checkOutput("rd_wait_addr", memAddr, 32'h100);
         checkBit("rd_wait_busy", arbBusy, 1'b1);
      end
      nextCycle();
      memStall = 0; memRdata = 32'hDEADBEEF; cpuCen = 0;
      sampleEdge();
      checkOutput("rd_done_rdata", cpuRdata, 32'hDEADBEEF);
      checkBit("rd_done_stall", cpuStall, 1'b0);
      checkBit("rd_done_owner", arbOwner, 1'b0);
      checkOutput("rd_done_coprdata", copRdata, 32'd0);
      nextCycle();
      applyStimulus();
      sampleEdge();
      checkBit("rd_idle_busy", arbBusy, 1'b0);

      // Simultaneous requests straight after reset: COP first.
      doReset();
      cpuCen = 1; cpuAddr = 32'h200; cpuBen = 4'hF;
      copCen = 1; copWen = 1; copAddr = 32'h300; copWdata = 32'h55; copBen = 4'h3;
      sampleEdge();
      checkBit("tie_owner", arbOwner, 1'b1);
      checkOutput("tie_addr", memAddr, 32'h300);
      checkBit("tie_wen", memWen, 1'b1);
      checkOutput("tie_wdata", memWdata, 32'h55);
      checkOutput("tie_ben", 32'(memBen), 32'h3);
      checkBit("tie_cpustall", cpuStall, 1'b1);
      nextCycle();
      copCen = 0; memRdata = 32'h1234;
      sampleEdge();
      checkBit("tie_cop_done", copStall, 1'b0);
      checkBit("tie_cpu_wait", cpuStall, 1'b1);
      checkOutput("tie_cpu_rdata", cpuRdata, 32'd0);
      checkBit("tie_nofwd", memCen, 1'b0);
      nextCycle();
      sampleEdge();
      checkBit("tie_cpu_owner", arbOwner, 1'b0);
      checkBit("tie_cpu_cen", memCen, 1'b1);
      checkOutput("tie_cpu_addr", memAddr, 32'h200);
      nextCycle();
      cpuCen = 0;
      sampleEdge();
      checkBit("tie_cpu_done", cpuStall, 1'b0);
      nextCycle();
      applyStimulus();

      // COP gather of 8 beats against a continuously requesting CPU.
      for (int c = 0; c < 14; c++) begin
         copCen = copCenT[c]; copAddr = copAddrT[c];
         cpuCen = cpuCenT[c]; cpuAddr = cpuAddrT[c];
         sampleEdge();
         checkBit($sformatf("lock_cen_c%0d", c), memCen, expCenT[c]);
         checkBit($sformatf("lock_owner_c%0d", c), arbOwner, expOwnT[c]);
         checkOutput($sformatf("lock_addr_c%0d", c), memAddr, expAddrT[c]);
         checkBit($sformatf("lock_copstall_c%0d", c), copStall, expCopStT[c]);
         checkBit($sformatf("lock_cpustall_c%0d", c), cpuStall, expCpuStT[c]);
         nextCycle();
      end
      applyStimulus();

      // COP store answered with a bus error.
      copCen = 1; copWen = 1; copAddr = 32'h400; copWdata = 32'hCAFE; copBen = 4'hF;
      sampleEdge();
      checkBit("err_issue_owner", arbOwner, 1'b1);
      checkOutput("err_issue_wdata", memWdata, 32'hCAFE);
      nextCycle();
      copAddr = 32'h404; memError = 1;
      sampleEdge();
      checkBit("err_cop_err", copError, 1'b1);
      checkBit("err_cpu_err", cpuError, 1'b0);
      checkBit("err_cop_stall", copStall, 1'b0);
      checkBit("err_nofwd", memCen, 1'b0);
      nextCycle();
      memError = 0;
      sampleEdge();
      checkBit("err_idle_busy", arbBusy, 1'b0);
      checkBit("err_cleared", copError, 1'b0);
      checkBit("err_reissue_cen", memCen, 1'b1);
      checkOutput("err_reissue_addr", memAddr, 32'h404);
      nextCycle();
      copCen = 0;
      sampleEdge();
      checkBit("err_reissue_done", copStall, 1'b0);
      checkBit("err_reissue_err", copError, 1'b0);
      nextCycle();
      applyStimulus();

      // Reset while the CPU waits on a stalled beat.
      cpuCen = 1; cpuAddr = 32'h500; cpuBen = 4'hF;
      nextCycle();
      memStall = 1;
      sampleEdge();
      checkBit("rst_mid_busy", arbBusy, 1'b1);
      reset = 1;
      nextCycle();
      reset = 0; cpuCen = 0; memStall = 0;
      sampleEdge();
      checkBit("rst_after_cen", memCen, 1'b0);
      checkBit("rst_after_busy", arbBusy, 1'b0);
      checkBit("rst_after_cpustall", cpuStall, 1'b0);
      checkBit("rst_after_copstall", copStall, 1'b0);
      nextCycle();

      // COP alone runs past LOCK_MAX; the count must saturate, not wrap.
      for (int b = 0; b < 5; b++) begin
         copCen = 1; copAddr = 32'h3000 + 32'(b * 4);
         sampleEdge();
         checkBit($sformatf("sat_cen_b%0d", b), memCen, 1'b1);
         checkBit($sformatf("sat_owner_b%0d", b), arbOwner, 1'b1);
         nextCycle();
      end
      copAddr = 32'h3014; cpuCen = 1; cpuAddr = 32'h600;
      sampleEdge();
      checkBit("sat_yield_cen", memCen, 1'b0);
      nextCycle();
      sampleEdge();
      checkBit("sat_cpu_owner", arbOwner, 1'b0);
      checkOutput("sat_cpu_addr", memAddr, 32'h600);
      nextCycle();
      applyStimulus();
      sampleEdge();
      checkBit("sat_cpu_done", cpuStall, 1'b0);
      nextCycle();
      sampleEdge();
      checkBit("sat_idle_busy", arbBusy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
